// File: rtl/btn_led_sequencer.sv
// rtl/btn_led_sequencer.sv - debounced button sequencer stepping a one-hot LED pattern for a fixed number of laps
module btn_led_sequencer #(
  parameter int TICK_DIV     = 50000000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int NUM_LEDS     = 8,
  parameter int LAPS         = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          state,
  output logic                busy,
  output logic                done_pulse
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW   = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int POSW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LW   = (LAPS > 1) ? $clog2(LAPS) : 1;

  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [POSW-1:0] POS_LAST  = POSW'(NUM_LEDS - 1);
  localparam logic [LW-1:0]   LAP_LAST  = LW'(LAPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

  logic          sync0, btn_s, btn_db, btn_db_q;
  logic [DW-1:0] deb_cnt;
  logic          press;

  logic [PW-1:0]       presc, presc_nx;
  logic [POSW-1:0]     pos, pos_nx;
  logic [LW-1:0]       lap, lap_nx;
  logic [1:0]          state_nx;
  logic                done_nx;
  logic                tick;
  logic [NUM_LEDS-1:0] led_nx;

  // The counter holds the number of mismatching cycles seen so far; the level
  // is accepted on the DEBOUNCE_CYC-th consecutive mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0    <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync0    <= btn;
      btn_s    <= sync0;
      btn_db_q <= btn_db;
      if (btn_s != btn_db) begin
        if (deb_cnt == DEB_LAST) begin
          btn_db  <= btn_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;
  assign tick  = (state == S_RUN) && (presc == TICK_LAST);

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    lap_nx   = lap;
    presc_nx = presc;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (press) begin
          state_nx = S_RUN;
          pos_nx   = '0;
          lap_nx   = '0;
          presc_nx = '0;
        end
      end
      S_RUN: begin
        presc_nx = tick ? '0 : presc + 1'b1;
        // A press in the same cycle as a tick pauses without stepping.
        if (press) begin
          state_nx = S_PAUSE;
        end else if (tick) begin
          if (pos == POS_LAST) begin
            pos_nx = '0;
            if (lap == LAP_LAST) begin
              state_nx = S_DONE;
              done_nx  = 1'b1;
            end else begin
              lap_nx = lap + 1'b1;
            end
          end else begin
            pos_nx = pos + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (press) state_nx = S_RUN;
      end
      default: begin
        if (press) state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    led_nx = '0;
    case (state_nx)
      S_RUN, S_PAUSE: led_nx = LED_ONE << pos_nx;
      S_DONE:         led_nx = '1;
      default:        led_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pos        <= '0;
      lap        <= '0;
      presc      <= '0;
      led        <= '0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      pos        <= pos_nx;
      lap        <= lap_nx;
      presc      <= presc_nx;
      led        <= led_nx;
      busy       <= (state_nx == S_RUN) || (state_nx == S_PAUSE);
      done_pulse <= done_nx;
    end
  end

endmodule

// File: tb/tb_btn_led_sequencer.sv
// tb/tb_btn_led_sequencer.sv - directed self-checking bench for btn_led_sequencer
module tb_btn_led_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn;
  logic [3:0] led;
  logic [1:0] state;
  logic       busy;
  logic       done_pulse;

  int errors = 0;
  int checks = 0;

  btn_led_sequencer #(
    .TICK_DIV(4),
    .DEBOUNCE_CYC(3),
    .NUM_LEDS(4),
    .LAPS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .led(led),
    .state(state),
    .busy(busy),
    .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one cycle after the press pulse, i.e. just after the state change.
  task automatic do_press;
    btn = 1'b1;
    step(4);
    btn = 1'b0;
    step(2);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    btn   = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    btn   = 1'b0;
    step(2);
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b expected 0000", led); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_pulse); end
    reset = 1'b0;
  endtask

  task automatic test_start;
    btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i == 5) begin
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_early: got state %0d expected 0", state); end
      end
      if (i == 6) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
        checks++; if (led !== 4'b0001) begin errors++; $display("FAIL start_led: got %b expected 0001", led); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
      end
    end
    btn = 1'b0;
  endtask

  task automatic test_full_run;
    logic [3:0] exp;
    for (int k = 13; k <= 37; k++) begin
      step(1);
      exp = 4'b0001 << (((k - 6) / 4) % 4);
      checks++; if (led !== exp || state !== 2'd1) begin errors++; $display("FAIL run_step%0d: got led %b state %0d expected led %b state 1", k, led, state, exp); end
    end
    step(1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL done_state: got %0d expected 3", state); end
    checks++; if (led !== 4'b1111) begin errors++; $display("FAIL done_led: got %b expected 1111", led); end
    checks++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL done_pulse_on: got %b expected 1", done_pulse); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy); end
    step(1);
    checks++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL done_pulse_off: got %b expected 0", done_pulse); end
    checks++; if (state !== 2'd3 || led !== 4'b1111) begin errors++; $display("FAIL done_hold: got state %0d led %b expected 3 1111", state, led); end
    step(2);
    do_press;
    checks++; if (state !== 2'd0 || led !== 4'b0000) begin errors++; $display("FAIL done_to_idle: got state %0d led %b expected 0 0000", state, led); end
  endtask

  task automatic test_glitch;
    step(4);
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++; if (state !== 2'd0 || led !== 4'b0000) begin errors++; $display("FAIL glitch_c%0d: got state %0d led %b expected 0 0000", i, state, led); end
    end
  endtask

  task automatic test_pause_resume;
    do_press;
    step(3);
    btn = 1'b1;
    step(4);
    btn = 1'b0;
    step(1);
    checks++; if (led !== 4'b0100 || state !== 2'd1) begin errors++; $display("FAIL pause_pre: got led %b state %0d expected 0100 1", led, state); end
    step(1);
    checks++; if (state !== 2'd2 || led !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL pause_enter: got state %0d led %b busy %b expected 2 0100 1", state, led, busy); end
    for (int i = 0; i < 40; i++) begin
      step(1);
      checks++; if (state !== 2'd2 || led !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL pause_hold%0d: got state %0d led %b busy %b expected 2 0100 1", i, state, led, busy); end
    end
    do_press;
    checks++; if (state !== 2'd1 || led !== 4'b0100) begin errors++; $display("FAIL resume_entry: got state %0d led %b expected 1 0100", state, led); end
    step(2);
    checks++; if (led !== 4'b0100) begin errors++; $display("FAIL resume_r2: got %b expected 0100", led); end
    step(1);
    checks++; if (led !== 4'b1000) begin errors++; $display("FAIL resume_r3: got %b expected 1000", led); end
  endtask

  task automatic test_collision;
    apply_reset;
    do_press;
    step(2);
    btn = 1'b1;
    step(4);
    btn = 1'b0;
    step(2);
    checks++; if (state !== 2'd2 || led !== 4'b0010) begin errors++; $display("FAIL collide_pause: got state %0d led %b expected 2 0010", state, led); end
    step(4);
    do_press;
    checks++; if (state !== 2'd1 || led !== 4'b0010) begin errors++; $display("FAIL collide_resume: got state %0d led %b expected 1 0010", state, led); end
    step(3);
    checks++; if (led !== 4'b0010) begin errors++; $display("FAIL collide_r3: got %b expected 0010", led); end
    step(1);
    checks++; if (led !== 4'b0100) begin errors++; $display("FAIL collide_r4: got %b expected 0100", led); end
  endtask

  task automatic test_reset_mid_run;
    apply_reset;
    do_press;
    step(24);
    checks++; if (led !== 4'b0100 || state !== 2'd1) begin errors++; $display("FAIL midrun_pre: got led %b state %0d expected 0100 1", led, state); end
    reset = 1'b1;
    step(1);
    checks++; if (state !== 2'd0 || led !== 4'b0000 || done_pulse !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_reset: got state %0d led %b done %b busy %b expected 0 0000 0 0", state, led, done_pulse, busy); end
    reset = 1'b0;
    do_press;
    checks++; if (state !== 2'd1 || led !== 4'b0001) begin errors++; $display("FAIL midrun_restart: got state %0d led %b expected 1 0001", state, led); end
    step(16);
    checks++; if (state !== 2'd1 || led !== 4'b0001) begin errors++; $display("FAIL midrun_lap0: got state %0d led %b expected 1 0001", state, led); end
  endtask

  initial begin
    reset = 1'b1;
    btn   = 1'b0;
    test_reset;
    test_start;
    test_full_run;
    test_glitch;
    test_pause_resume;
    test_collision;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
